mem_stage_port: RTL and testbench
=================================

# mem_stage_port

Memory-stage responder consuming the EX/MEM pipeline register outputs: it takes the latched address, store data, access-enable and read/write select, services one word access against an internal single-port data RAM with fixed multi-cycle latency, and raises a stall while the access is in flight. It sits between the EX/MEM register and the MEM/WB register. It returns read data and a one-cycle completion pulse toward writeback.

## Interface
- DEPTH, 256: RAM depth in 32-bit words; power of two, ≥ 4.
- LAT, 2: wait cycles before the RAM access edge; 1 ≤ LAT ≤ 15.
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- ALURESULT  in  32  byte address of the access.
- DATA5  in  32  store data.
- DATAINPUTON  in  1  access request valid.
- DATAINPUTS  in  1  access select: 1 = write (store), 0 = read (load).
- ReadData  out  32  last completed load value, registered.
- Stall  out  1  hold pipeline; combinational from state and DATAINPUTON.
- Done  out  1  one-cycle completion pulse, registered state.
- AddrErr  out  1  completed access was misaligned or out of range; valid with Done.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, DATAINPUTON=0: stay in IDLE.
- IDLE, DATAINPUTON=1: at the next edge, latch address/data/select into internal registers, load counter with LAT-1, go to WAIT.
- WAIT, counter≠0: decrement the counter.
- WAIT, counter=0: perform the RAM access at this edge, go to DONE.
- DONE: unconditionally return to IDLE; a request present during DONE is not sampled.
- Stall = (state==WAIT) | (state==IDLE & DATAINPUTON).
  - Stall is low in DONE so the EX/MEM register advances exactly once per access and the same request is never serviced twice.
- Done = (state==DONE).
- Address decode:
  - word index = ALURESULT[AW+1:2], where AW = log2(DEPTH).
  - Error when ALURESULT[1:0]≠0 or any ALURESULT[31:AW+2]≠0.
- Errored access:
  - Runs the full latency.
  - No RAM write.
  - Load writes 0 into ReadData.
  - AddrErr=1 during DONE.
- Valid write: RAM[index] ← latched data at the access edge; ReadData unchanged.
- Valid read: ReadData ← RAM[index] at the access edge, i.e. the pre-write contents; no write occurs on a read.
- Inputs are sampled only at the IDLE→WAIT edge; changes to inputs during WAIT are ignored.
- Reset values: state IDLE, counter 0, ReadData 0, Done 0, AddrErr 0.
  - Stall follows its equation after reset, so it is 1 if DATAINPUTON=1 in IDLE.
  - RAM contents are not reset.
- Reset mid-operation: reset has priority at every edge.
  - A write whose access edge coincides with reset is discarded.
  - Latched request is dropped; no Done pulse.

## Timing
- Request presented in cycle 0 (IDLE): Stall=1 in cycles 0..LAT; Done=1 in cycle LAT+1.
- Total access: LAT+2 cycles, including the DONE cycle; back-to-back throughput is one access per LAT+2 cycles.
- ReadData is valid from cycle LAT+1 and holds until the next completed load.
- AddrErr is 0 outside DONE.
- No combinational path from ALURESULT/DATA5 to any output.

## Structure
- Package mem_pkg holds:
  - state enum (IDLE, WAIT, DONE);
  - default DEPTH/LAT constants;
  - ADDR_ALIGN_MASK = 2'b11.
- Sub-module dmem_ram: single-port synchronous RAM, DEPTH×32.
  - Ports: clk, we, addr, wdata, rdata.
  - Registered read, read-before-write.
- Top-level logic: FSM, counter, request latches, decode and the ReadData register.

## Test plan
- Reset then idle: reset=1 for 2 cycles with DATAINPUTON=0 → ReadData=0, Done=0, AddrErr=0, Stall=0.
- Store/load, LAT=2:
  - Write 0xDEADBEEF to 0x10 → Stall high cycles 0–2, Done in cycle 3, ReadData unchanged.
  - Read 0x10 → Done in cycle 3, ReadData=0xDEADBEEF.
- Misaligned access: write to 0x12, then read 0x10 → AddrErr=1 with Done on the write; read returns the prior value 0xDEADBEEF.
- Out of range (DEPTH=256): read 0x400 → AddrErr=1, ReadData=0.
- Held request: hold DATAINPUTON=1 with the same inputs for 8 cycles, modelling the EX/MEM register stalled then advancing → exactly two Done pulses, in cycles 3 and 7.
- Reset mid-access: assert reset in cycle 2 of a write of 0x12345678 to 0x20; subsequent read of 0x20 → old contents, and no Done for the aborted write.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage responder.
// Holds the FSM state encoding, default geometry and the address-error decode.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DEPTH = 256;
    localparam int DEF_LAT   = 2;

    localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

    // A byte address is bad if it is not word aligned or lies beyond the RAM.
    function automatic logic addr_err(input logic [31:0] addr, input int aw);
        return ((addr[1:0] & ADDR_ALIGN_MASK) != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM, DEPTH x 32.
// Registered read with read-before-write behaviour on a shared address.
module dmem_ram
    import mem_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // NOTE: the array has no reset branch on purpose; resetting it would turn
    // the RAM into a flop bank instead of a memory macro.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_stage_port.sv
// Memory-stage responder between EX/MEM and MEM/WB: one word access per
// request against an internal RAM, with a fixed wait latency and a stall.
module mem_stage_port
    import mem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int LAT   = DEF_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALURESULT,
    input  logic [31:0] DATA5,
    input  logic        DATAINPUTON,
    input  logic        DATAINPUTS,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Done,
    output logic        AddrErr
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] LAT_LOAD = 4'(LAT - 1);

    state_t        state;
    state_t        state_nx;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          wr_q;
    logic          err_q;

    logic          accept;
    logic          access;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;

    assign accept = (state == IDLE) && DATAINPUTON;
    assign access = (state == WAIT) && (cnt == 4'd0);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (DATAINPUTON) state_nx = WAIT;
            WAIT:    if (cnt == 4'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign Stall   = (state == WAIT) || accept;
    assign Done    = (state == DONE);
    assign AddrErr = (state == DONE) && err_q;

    // The RAM tracks the incoming address while idle so that its registered
    // read already holds the target word by the time the access edge arrives.
    assign ram_addr = (state == IDLE) ? ALURESULT[AW+1:2] : idx_q;
    assign ram_we   = access && wr_q && !err_q && !reset;

    dmem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            idx_q    <= '0;
            wdata_q  <= 32'd0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            ReadData <= 32'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                idx_q   <= ALURESULT[AW+1:2];
                wdata_q <= DATA5;
                wr_q    <= DATAINPUTS;
                err_q   <= addr_err(ALURESULT, AW);
                cnt     <= LAT_LOAD;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (access && !wr_q) begin
                ReadData <= err_q ? 32'd0 : ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_port.sv
// Scoreboard bench for mem_stage_port: the driver pushes expected completions
// from a word-array model, and a monitor pops them whenever Done is seen.
module tb_mem_stage_port;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk;
    logic        reset;
    logic [31:0] ALURESULT;
    logic [31:0] DATA5;
    logic        DATAINPUTON;
    logic        DATAINPUTS;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Done;
    logic        AddrErr;

    mem_stage_port #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .ALURESULT   (ALURESULT),
        .DATA5       (DATA5),
        .DATAINPUTON (DATAINPUTON),
        .DATAINPUTS  (DATAINPUTS),
        .ReadData    (ReadData),
        .Stall       (Stall),
        .Done        (Done),
        .AddrErr     (AddrErr)
    );

    typedef struct {
        int          cyc;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [int];
    logic [31:0] last_rd;
    int          total;
    int          bad;
    int          cyc;
    bit          mon_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_err(input logic [31:0] addr);
        return (addr % 4 != 0) || (addr >= DEPTH * 4);
    endfunction

    // Apply a request to the model and return the completion it should produce.
    function automatic exp_t model_access(input logic [31:0] addr, input logic [31:0] data,
                                          input bit wr, input int done_cyc);
        exp_t e;
        e.cyc = done_cyc;
        e.err = model_err(addr);
        if (wr) begin
            if (!e.err) mem_m[int'(addr / 4)] = data;
        end else begin
            last_rd = e.err ? 32'd0 : mem_m[int'(addr / 4)];
        end
        e.rd = last_rd;
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (Done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    check("read_data", ReadData, e.rd);
                    check("addr_err", {31'd0, AddrErr}, {31'd0, e.err});
                end
            end else begin
                check("addr_err_idle", {31'd0, AddrErr}, 32'd0);
            end
        end
    end

    // Entered just after a rising edge; leaves just after the edge ending DONE.
    task automatic issue(input logic [31:0] addr, input logic [31:0] data, input bit wr);
        ALURESULT   = addr;
        DATA5       = data;
        DATAINPUTS  = wr;
        DATAINPUTON = 1'b1;
        sb.push_back(model_access(addr, data, wr, cyc + LAT + 1));
        for (int k = 0; k <= LAT + 1; k++) begin
            @(negedge clk);
            check("stall", {31'd0, Stall}, {31'd0, (k <= LAT)});
            if (k == 1) begin
                ALURESULT = $urandom;
                DATA5     = $urandom;
            end
        end
        @(posedge clk);
        #1;
        DATAINPUTON = 1'b0;
    endtask

    task automatic idle(input int n);
        DATAINPUTON = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("stall_idle", {31'd0, Stall}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total       = 0;
        bad         = 0;
        cyc         = 0;
        mon_en      = 1'b0;
        last_rd     = 32'd0;
        reset       = 1'b1;
        ALURESULT   = 32'd0;
        DATA5       = 32'd0;
        DATAINPUTON = 1'b0;
        DATAINPUTS  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_read_data", ReadData, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_stall", {31'd0, Stall}, 32'd0);
        @(posedge clk);
        #1;

        for (int w = 0; w < 16; w++) issue(32'(w * 4), $urandom, 1'b1);

        issue(32'h10, 32'hDEADBEEF, 1'b1);
        issue(32'h10, 32'h0, 1'b0);
        issue(32'h12, 32'hCAFEF00D, 1'b1);
        issue(32'h10, 32'h0, 1'b0);
        issue(32'h400, 32'h0, 1'b0);
        idle(2);

        // Held request: the EX/MEM register stays put, so the same load is
        // sampled twice in eight cycles.
        begin
            int c0;
            c0          = cyc;
            ALURESULT   = 32'h10;
            DATAINPUTS  = 1'b0;
            DATAINPUTON = 1'b1;
            sb.push_back(model_access(32'h10, 32'h0, 1'b0, c0 + 3));
            sb.push_back(model_access(32'h10, 32'h0, 1'b0, c0 + 7));
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                check("stall_held", {31'd0, Stall}, {31'd0, !(k == 3 || k == 7)});
                @(posedge clk);
                #1;
            end
            DATAINPUTON = 1'b0;
        end
        idle(1);

        // Reset lands on the access edge of a store: it must be dropped.
        ALURESULT   = 32'h20;
        DATA5       = 32'h12345678;
        DATAINPUTS  = 1'b1;
        DATAINPUTON = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("stall_abort", {31'd0, Stall}, 32'd1);
            @(posedge clk);
            #1;
        end
        reset       = 1'b1;
        DATAINPUTON = 1'b0;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        last_rd = 32'd0;
        @(negedge clk);
        check("post_reset_read_data", ReadData, 32'd0);
        @(posedge clk);
        #1;
        issue(32'h20, 32'h0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0:       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                1:       a = 32'h400 + 32'($urandom_range(0, 4095));
                default: a = 32'($urandom_range(0, 15) * 4);
            endcase
            issue(a, $urandom, 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end

        idle(4);
        check("pending_completions", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
